// File: rtl/i2c_pkg.sv
// Shared I2C definitions: byte-engine command opcodes, sequencer states and
// the step-to-opcode map used by the transaction sequencer.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;
  localparam logic RD_BIT = 1'b1;
  localparam logic WR_BIT = 1'b0;
  localparam logic [2:0] WR_STOP_STEP = 3'd4;
  localparam logic [2:0] RD_STOP_STEP = 3'd6;

  typedef enum logic [2:0] {
    CMD_START   = 3'd0,
    CMD_WRITE   = 3'd1,
    CMD_READ    = 3'd2,
    CMD_RESTART = 3'd3,
    CMD_STOP    = 3'd4
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_e;

  // Write: START, WR addr, WR reg, WR data, STOP.
  // Read:  START, WR addr, WR reg, RESTART, WR addr|1, READ, STOP.
  function automatic cmd_op_e step_op(input logic rnw, input logic [2:0] step);
    cmd_op_e op;
    op = CMD_STOP;
    if (rnw) begin
      case (step)
        3'd0:       op = CMD_START;
        3'd1, 3'd2: op = CMD_WRITE;
        3'd3:       op = CMD_RESTART;
        3'd4:       op = CMD_WRITE;
        3'd5:       op = CMD_READ;
        default:    op = CMD_STOP;
      endcase
    end else begin
      case (step)
        3'd0:             op = CMD_START;
        3'd1, 3'd2, 3'd3: op = CMD_WRITE;
        default:          op = CMD_STOP;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first valid index
// strictly after ptr, wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx
);

  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && valid[i] && (i > int'(ptr))) begin
        grant[i]  = 1'b1;
        grant_idx = PTR_W'(i);
        found     = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && valid[i] && (i <= int'(ptr))) begin
        grant[i]  = 1'b1;
        grant_idx = PTR_W'(i);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_req_sequencer.sv
// Shares one I2C byte engine between NUM_REQ register-access requesters,
// sequencing START/WRITE/RESTART/READ/STOP commands per transaction.
module i2c_req_sequencer
  import i2c_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = I2C_ADDR_W,
  parameter int DATA_W  = I2C_BYTE_W
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0]        req_rnw_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_reg_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      cmd_valid_o,
  input  logic                      cmd_ready_i,
  output cmd_op_e                   cmd_op_o,
  output logic [DATA_W-1:0]         cmd_data_o,
  output logic                      cmd_nack_o,
  input  logic                      done_valid_i,
  input  logic [DATA_W-1:0]         done_data_i,
  input  logic                      done_nack_i,
  output logic                      busy_o,
  output seq_state_e                dbg_state_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshakes: a request/command transfers on the edge where valid and ready
  // are both high; the offering side holds its payload stable until then.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  seq_state_e          state_q, state_d;
  logic [2:0]          step_q, step_d;
  logic [PTR_W-1:0]    ptr_q, grant_idx;
  logic [NUM_REQ-1:0]  owner_q, grant, arb_valid;
  logic                rnw_q, err_q, grant_en_q, accept;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   reg_q, wdata_q, rdata_q, cur_data;
  logic [2:0]          last_step;
  cmd_op_e             cur_op;

  assign arb_valid = (state_q == ST_IDLE && grant_en_q) ? req_valid_i : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .valid     (arb_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept    = |grant;
  assign cur_op    = step_op(rnw_q, step_q);
  assign last_step = rnw_q ? RD_STOP_STEP : WR_STOP_STEP;

  always_comb begin
    cur_data = '0;
    if (cur_op == CMD_WRITE) begin
      case (step_q)
        3'd1:    cur_data = DATA_W'({addr_q, WR_BIT});
        3'd2:    cur_data = reg_q;
        3'd3:    cur_data = wdata_q;
        3'd4:    cur_data = DATA_W'({addr_q, RD_BIT});
        default: cur_data = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ISSUE;
          step_d  = '0;
        end
      end
      ST_ISSUE: if (cmd_ready_i) state_d = ST_WAIT;
      ST_WAIT: begin
        if (done_valid_i) begin
          if (step_q == last_step) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
            // A NACKed byte abandons the transfer but still releases the bus.
            step_d  = (cur_op == CMD_WRITE && done_nack_i) ? last_step : step_q + 3'd1;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      ptr_q      <= PTR_W'(NUM_REQ - 1);
      owner_q    <= '0;
      grant_en_q <= 1'b0;
      rnw_q      <= 1'b0;
      addr_q     <= '0;
      reg_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      grant_en_q <= 1'b1;
      if (accept) begin
        ptr_q   <= grant_idx;
        owner_q <= grant;
        rnw_q   <= req_rnw_i[grant_idx];
        addr_q  <= req_addr_i[grant_idx*ADDR_W +: ADDR_W];
        reg_q   <= req_reg_i[grant_idx*DATA_W +: DATA_W];
        wdata_q <= req_wdata_i[grant_idx*DATA_W +: DATA_W];
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
      if (state_q == ST_WAIT && done_valid_i) begin
        if (cur_op == CMD_READ) rdata_q <= done_data_i;
        if (cur_op == CMD_WRITE && done_nack_i) err_q <= 1'b1;
      end
    end
  end

  assign req_ready_o = grant;
  assign cmd_valid_o = (state_q == ST_ISSUE);
  assign cmd_op_o    = cmd_valid_o ? cur_op : CMD_START;
  assign cmd_data_o  = cmd_valid_o ? cur_data : '0;
  assign cmd_nack_o  = cmd_valid_o && (cur_op == CMD_READ);
  assign rsp_valid_o = (state_q == ST_RESP) ? owner_q : '0;
  assign rsp_rdata_o = (state_q == ST_RESP && !err_q) ? rdata_q : '0;
  assign rsp_err_o   = (state_q == ST_RESP) && err_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule
